mac_job_sched: RTL and testbench
================================

MAC_JOB_SCHED -- requirements
Module: mac_job_sched

Interface
REQ-001 SHALL have parameter ACC_W, default 12, accumulator and result width (ACC_W >= 8).
REQ-002 SHALL have parameter LEN_W, default 4, job-length field width.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port req, input, 2, per-requester job request, bit i = requester i.
REQ-006 SHALL have ports len0 and len1, input, LEN_W each, operand-pair count of the job from requester 0 / 1.
REQ-007 SHALL have port gnt, output, 2, one-hot grant to the requester owning the MAC.
REQ-008 SHALL have ports op_valid, input, 1, and op_ready, output, 1: shared operand-stream handshake.
REQ-009 SHALL have ports op_a and op_b, input, 4 each, unsigned operands, driven by the granted requester.
REQ-010 SHALL have ports res_valid, output, 1, and res_ready, input, 1: result handshake.
REQ-011 SHALL have port res_data, output, ACC_W, dot-product result.
REQ-012 SHALL have port res_id, output, 1, index of the requester that owns res_data.
REQ-013 SHALL have port ovf, output, 1, accumulator overflow flag.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and RESP.
REQ-015 In IDLE, when req != 0: SHALL grant one requester, latch its len into the beat counter, clear acc to 0, and go to RUN (len != 0) or RESP (len == 0).
REQ-016 When both req bits are set in IDLE: SHALL grant the requester selected by the round-robin pointer; when one bit is set, that requester SHALL win regardless of the pointer.
REQ-017 The pointer SHALL move to the non-granted requester on every grant.
REQ-018 gnt SHALL be registered, SHALL assert on the cycle RUN/RESP is entered, and SHALL hold until the cycle after the result handshake.
REQ-019 gnt SHALL be 0 in IDLE.
REQ-020 op_ready SHALL be 1 only in RUN.
REQ-021 On a beat (op_valid && op_ready): acc SHALL become acc + op_a*op_b (8-bit product, zero-extended) and the beat counter SHALL decrement.
REQ-022 On the beat that takes the counter to 0: SHALL go to RESP on the next edge.
REQ-023 op_valid low in RUN SHALL stall without state change; there is no timeout.
REQ-024 In RESP: res_valid SHALL be 1, res_data SHALL equal acc, and res_id SHALL equal the granted index.
REQ-025 res_data and res_id SHALL be stable until res_ready.
REQ-026 When res_valid && res_ready: SHALL return to IDLE.
REQ-027 A new grant SHALL occur no earlier than the cycle after the return to IDLE.
REQ-028 Changes to req or len during RUN/RESP SHALL be ignored; the job in progress SHALL complete.
REQ-029 A zero-length job SHALL return res_data = 0 one cycle after the grant.

Reset
REQ-030 On rst at a clock edge, from any state: FSM SHALL go to IDLE; gnt, op_ready, res_valid, res_data, res_id and ovf SHALL be 0; acc SHALL be 0; pointer SHALL select requester 0.
REQ-031 A job in flight at reset SHALL be discarded with no result.

Configuration
REQ-032 With MAC_JOB_SAT_EN defined: acc SHALL saturate at 2^ACC_W-1, and ovf SHALL set on the saturating beat and hold until the next grant or rst.
REQ-033 Without MAC_JOB_SAT_EN: acc SHALL wrap modulo 2^ACC_W, and ovf SHALL be constant 0.

Structure
REQ-034 The shared package SHALL hold the FSM state enum (IDLE/RUN/RESP), the 4-bit operand width constant and the 8-bit product width constant.
REQ-035 Round-robin selection SHALL be a sub-module mac_rr_arb2 (inputs req, ptr; output one-hot grant).

Verification
REQ-036 rst mid-RUN after 2 beats -> next cycle IDLE, all outputs 0; next req[0]=1 grants requester 0.
REQ-037 req=01, len0=3, beats (2,3),(4,5),(15,15) -> res_valid with res_data=251, res_id=0; gnt=01 throughout.
REQ-038 req=11 persistent, len0=len1=1, res_ready=1 -> grants alternate 01,10,01; res_id alternates 0,1,0.
REQ-039 len1=0, req=10 -> RESP one cycle after the grant with res_data=0 and res_id=1; op_ready never asserts.
REQ-040 ACC_W=8, len0=2, beats (15,15),(15,15) -> with MAC_JOB_SAT_EN: res_data=255, ovf=1; without: res_data=194, ovf=0.
REQ-041 op_valid low for 5 cycles mid-job, then res_ready held low 3 cycles in RESP -> counter and acc unchanged while stalled; res_data stable until the handshake.

Source files
------------

// File: rtl/mac_job_sched_pkg.sv
// Shared types and constants for the MAC job scheduler.
// Optional feature macro: MAC_JOB_SAT_EN (saturating accumulator with overflow flag).
package mac_job_sched_pkg;

    localparam int unsigned OP_W    = 4;
    localparam int unsigned PROD_W  = 8;
    localparam int unsigned NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_e;

    // Unsigned operand product, zero-extended to the product width before multiplying.
    function automatic logic [PROD_W-1:0] mul_op(input logic [OP_W-1:0] a,
                                                 input logic [OP_W-1:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction

endpackage

// File: rtl/mac_rr_arb2.sv
// Two-requester round-robin selector: a lone requester always wins, a tie goes to ptr.
module mac_rr_arb2
    import mac_job_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               ptr,
    output logic [NUM_REQ-1:0] gnt_c
);

    always_comb begin
        gnt_c = '0;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = ptr ? 2'b10 : 2'b01;
            default: gnt_c = '0;
        endcase
    end

endmodule

// File: rtl/mac_job_sched.sv
// Shares one 4x4 MAC between two requesters; each job is a dot product of len operand pairs.
// Optional feature macro: MAC_JOB_SAT_EN (saturate accumulator at all-ones and raise ovf).
module mac_job_sched
    import mac_job_sched_pkg::*;
#(
    parameter int unsigned ACC_W = 12,
    parameter int unsigned LEN_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [LEN_W-1:0]    len0,
    input  logic [LEN_W-1:0]    len1,
    output logic [NUM_REQ-1:0]  gnt,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [OP_W-1:0]     op_a,
    input  logic [OP_W-1:0]     op_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ACC_W-1:0]    res_data,
    output logic                res_id,
    output logic                ovf
);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic                 ptr_q, ptr_d;
    logic                 res_id_q, res_id_d;
    logic                 op_ready_q, op_ready_d;
    logic                 res_valid_q, res_valid_d;

    logic [NUM_REQ-1:0]   arb_gnt_c;
    logic [LEN_W-1:0]     sel_len_c;
    logic                 start_c;
    logic                 beat_c;
    logic [PROD_W-1:0]    prod_c;
    logic [ACC_W-1:0]     acc_next_c;

    mac_rr_arb2 u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .gnt_c (arb_gnt_c)
    );

    assign start_c   = (state_q == IDLE) && (req != 2'b00);
    assign beat_c    = op_valid && (state_q == RUN);
    assign sel_len_c = arb_gnt_c[1] ? len1 : len0;
    assign prod_c    = mul_op(op_a, op_b);

`ifdef MAC_JOB_SAT_EN
    localparam int unsigned SUM_W = ACC_W + 1;

    logic [SUM_W-1:0] sum_c;
    logic             ovf_q, ovf_d;

    // Carry out of the accumulator width means the true sum no longer fits.
    assign sum_c      = SUM_W'(acc_q) + SUM_W'(prod_c);
    assign acc_next_c = sum_c[ACC_W] ? {ACC_W{1'b1}} : sum_c[ACC_W-1:0];

    always_comb begin
        ovf_d = ovf_q;
        if (start_c) begin
            ovf_d = 1'b0;
        end else if (beat_c && sum_c[ACC_W]) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign acc_next_c = acc_q + ACC_W'(prod_c);
    assign ovf        = 1'b0;
`endif

    // Job sequencing: grant in IDLE, accumulate in RUN, hold the result in RESP.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ptr_d    = ptr_q;
        res_id_d = res_id_q;

        case (state_q)
            IDLE: begin
                if (start_c) begin
                    gnt_d    = arb_gnt_c;
                    res_id_d = arb_gnt_c[1];
                    ptr_d    = ~arb_gnt_c[1];
                    acc_d    = '0;
                    cnt_d    = sel_len_c;
                    state_d  = (sel_len_c == '0) ? RESP : RUN;
                end
            end
            RUN: begin
                if (beat_c) begin
                    acc_d = acc_next_c;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (res_ready) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        op_ready_d  = (state_d == RUN);
        res_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ptr_q       <= 1'b0;
            res_id_q    <= 1'b0;
            op_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ptr_q       <= ptr_d;
            res_id_q    <= res_id_d;
            op_ready_q  <= op_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign op_ready  = op_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = acc_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_mac_job_sched.sv
// Directed bench for mac_job_sched: an 8-bit accumulator instance and a default 12-bit one share stimulus.
module tb_mac_job_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [3:0]  len0, len1;
    logic        op_valid;
    logic [3:0]  op_a, op_b;
    logic        res_ready;

    logic [1:0]  gnt8, gnt12;
    logic        op_ready8, op_ready12;
    logic        res_valid8, res_valid12;
    logic [7:0]  res_data8;
    logic [11:0] res_data12;
    logic        res_id8, res_id12;
    logic        ovf8, ovf12;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_g;

`ifdef MAC_JOB_SAT_EN
    localparam logic [7:0] EXP_SAT_DATA = 8'd255;
    localparam logic       EXP_OVF      = 1'b1;
`else
    localparam logic [7:0] EXP_SAT_DATA = 8'd194;
    localparam logic       EXP_OVF      = 1'b0;
`endif

    mac_job_sched #(.ACC_W(8), .LEN_W(4)) dut8 (
        .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1), .gnt(gnt8),
        .op_valid(op_valid), .op_ready(op_ready8), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid8), .res_ready(res_ready), .res_data(res_data8),
        .res_id(res_id8), .ovf(ovf8)
    );

    mac_job_sched dut12 (
        .clk(clk), .rst(rst), .req(req), .len0(len0), .len1(len1), .gnt(gnt12),
        .op_valid(op_valid), .op_ready(op_ready12), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid12), .res_ready(res_ready), .res_data(res_data12),
        .res_id(res_id12), .ovf(ovf12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; len0 = '0; len1 = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        tick(); tick();
        chk("rst_gnt", 16'(gnt8), 16'd0);
        chk("rst_op_ready", 16'(op_ready8), 16'd0);
        chk("rst_res_valid", 16'(res_valid8), 16'd0);
        chk("rst_res_data", 16'(res_data8), 16'd0);
        chk("rst_res_id", 16'(res_id8), 16'd0);
        chk("rst_ovf", 16'(ovf8), 16'd0);
        chk("rst_gnt12", 16'(gnt12), 16'd0);
        rst = 1'b0;

        // Round-robin alternation with both requesters asking continuously
        req = 2'b11; len0 = 4'd1; len1 = 4'd1; res_ready = 1'b1;
        op_valid = 1'b1; op_a = 4'd1; op_b = 4'd1;
        for (int k = 0; k < 3; k++) begin
            exp_g = (k == 1) ? 2'b10 : 2'b01;
            tick();
            chk("rr_gnt", 16'(gnt8), 16'(exp_g));
            chk("rr_op_ready", 16'(op_ready8), 16'd1);
            tick();
            chk("rr_res_valid", 16'(res_valid8), 16'd1);
            chk("rr_res_id", 16'(res_id8), (k == 1) ? 16'd1 : 16'd0);
            chk("rr_res_data", 16'(res_data8), 16'd1);
            if (k == 2) req = 2'b00;
            tick();
            chk("rr_idle_gnt", 16'(gnt8), 16'd0);
        end
        op_valid = 1'b0; res_ready = 1'b0;

        // Reset in the middle of a job after two beats
        req = 2'b01; len0 = 4'd5;
        tick();
        chk("mid_gnt", 16'(gnt8), 16'd1);
        req = 2'b00; op_valid = 1'b1;
        tick(); tick();
        chk("mid_op_ready", 16'(op_ready8), 16'd1);
        chk("mid_res_valid", 16'(res_valid8), 16'd0);
        rst = 1'b1; op_valid = 1'b0;
        tick();
        chk("mid_rst_gnt", 16'(gnt8), 16'd0);
        chk("mid_rst_op_ready", 16'(op_ready8), 16'd0);
        chk("mid_rst_res_valid", 16'(res_valid8), 16'd0);
        chk("mid_rst_res_data", 16'(res_data8), 16'd0);
        chk("mid_rst_res_id", 16'(res_id8), 16'd0);
        chk("mid_rst_ovf", 16'(ovf8), 16'd0);
        rst = 1'b0; req = 2'b11; len0 = 4'd0; len1 = 4'd0;
        tick();
        chk("post_rst_ptr_gnt", 16'(gnt8), 16'd1);
        chk("post_rst_res_valid", 16'(res_valid8), 16'd1);
        chk("post_rst_res_data", 16'(res_data8), 16'd0);
        req = 2'b00; res_ready = 1'b1;
        tick();
        chk("post_rst_idle_gnt", 16'(gnt8), 16'd0);
        chk("post_rst_idle_valid", 16'(res_valid8), 16'd0);
        res_ready = 1'b0;

        // Three-beat dot product 2*3 + 4*5 + 15*15 = 251 (requester 0 alone, pointer at 1)
        req = 2'b01; len0 = 4'd3;
        tick();
        chk("dot_gnt0", 16'(gnt8), 16'd1);
        req = 2'b00; op_valid = 1'b1; op_a = 4'd2; op_b = 4'd3;
        tick();
        chk("dot_gnt1", 16'(gnt8), 16'd1);
        op_a = 4'd4; op_b = 4'd5;
        tick();
        chk("dot_gnt2", 16'(gnt8), 16'd1);
        op_a = 4'd15; op_b = 4'd15;
        tick();
        op_valid = 1'b0;
        chk("dot_res_valid", 16'(res_valid8), 16'd1);
        chk("dot_res_data8", 16'(res_data8), 16'd251);
        chk("dot_res_data12", 16'(res_data12), 16'd251);
        chk("dot_res_id", 16'(res_id8), 16'd0);
        chk("dot_gnt_resp", 16'(gnt8), 16'd1);
        chk("dot_op_ready_resp", 16'(op_ready8), 16'd0);
        res_ready = 1'b1;
        tick();
        chk("dot_idle_valid", 16'(res_valid8), 16'd0);
        chk("dot_idle_gnt", 16'(gnt8), 16'd0);
        res_ready = 1'b0;

        // Zero-length job from requester 1
        req = 2'b10; len1 = 4'd0;
        tick();
        chk("zero_gnt", 16'(gnt8), 16'd2);
        chk("zero_res_valid", 16'(res_valid8), 16'd1);
        chk("zero_res_data", 16'(res_data8), 16'd0);
        chk("zero_res_id", 16'(res_id8), 16'd1);
        chk("zero_op_ready", 16'(op_ready8), 16'd0);
        req = 2'b00; res_ready = 1'b1;
        tick();
        chk("zero_idle_op_ready", 16'(op_ready8), 16'd0);
        chk("zero_idle_gnt", 16'(gnt8), 16'd0);
        res_ready = 1'b0;

        // Accumulator overflow: 225 + 225 = 450
        req = 2'b01; len0 = 4'd2;
        tick();
        chk("ovf_gnt", 16'(gnt8), 16'd1);
        req = 2'b00; op_valid = 1'b1; op_a = 4'd15; op_b = 4'd15;
        tick(); tick();
        op_valid = 1'b0;
        chk("ovf_res_valid", 16'(res_valid8), 16'd1);
        chk("ovf_res_data8", 16'(res_data8), 16'(EXP_SAT_DATA));
        chk("ovf_flag8", 16'(ovf8), 16'(EXP_OVF));
        chk("ovf_res_data12", 16'(res_data12), 16'd450);
        chk("ovf_flag12", 16'(ovf12), 16'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("ovf_hold_idle", 16'(ovf8), 16'(EXP_OVF));

        // Stall five cycles mid-job, ignore req/len changes, then back-pressure the result
        req = 2'b01; len0 = 4'd3;
        tick();
        chk("stall_gnt", 16'(gnt8), 16'd1);
        chk("stall_ovf_cleared", 16'(ovf8), 16'd0);
        req = 2'b00; op_valid = 1'b1; op_a = 4'd3; op_b = 4'd4;
        tick();
        op_valid = 1'b0; req = 2'b10; len0 = 4'd9; len1 = 4'd7;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_op_ready", 16'(op_ready8), 16'd1);
            chk("stall_res_valid", 16'(res_valid8), 16'd0);
            chk("stall_gnt_hold", 16'(gnt8), 16'd1);
        end
        op_valid = 1'b1; op_a = 4'd2; op_b = 4'd2;
        tick();
        chk("stall_beat2_valid", 16'(res_valid8), 16'd0);
        op_a = 4'd1; op_b = 4'd5;
        tick();
        op_valid = 1'b0;
        chk("stall_res_valid_on", 16'(res_valid8), 16'd1);
        chk("stall_res_data", 16'(res_data8), 16'd21);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_res_valid", 16'(res_valid8), 16'd1);
            chk("bp_res_data", 16'(res_data8), 16'd21);
            chk("bp_res_id", 16'(res_id8), 16'd0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_idle_valid", 16'(res_valid8), 16'd0);
        chk("bp_idle_gnt", 16'(gnt8), 16'd0);
        res_ready = 1'b0;
        tick();
        chk("next_grant_req1", 16'(gnt8), 16'd2);
        req = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
